fifo_wr_arb: RTL and testbench

Frame-level round-robin arbiter that shares the single write port of the MAC's asynchronous FIFO between two byte-stream requesters (e.g. the TX frame builder and the pause-frame generator). A grant is held for a whole frame from first beat to `last`, so frames never interleave inside the FIFO. FIFO `full` is honoured as backpressure. A per-frame length report and per-source frame counters are exported for status. Lives entirely in the FIFO write-clock domain.

---
 rtl/fifo_wr_arb_if.sv | 64 ++++++
 rtl/fifo_wr_arb.sv | 178 +++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_if
// Bundles every signal between the frame arbiter and its surroundings: the two
// byte-stream requesters, the FIFO write port and the status outputs.
//
// Signals
//   s0_data/s0_valid/s0_last  requester 0 beat (to arbiter)
//   s0_ready                  requester 0 accept (from arbiter)
//   s1_*                      same for requester 1
//   fifo_full                 FIFO backpressure (to arbiter)
//   fifo_w_en, fifo_data      FIFO write port (from arbiter)
//   grant                     one-hot current owner, 2'b00 when idle
//   frame_len, frame_len_vld  length of last completed frame + update pulse
//   frame_cnt0, frame_cnt1    completed frames per requester
//
// Modports
//   slave  : the arbiter side
//   master : the environment side (requesters, FIFO, status consumer)
// -----------------------------------------------------------------------------
interface fifo_wr_arb_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 11,
  parameter int CNT_W = 16
) ();

  logic [WIDTH-1:0] s0_data;
  logic             s0_valid;
  logic             s0_last;
  logic             s0_ready;

  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;
  logic             s1_last;
  logic             s1_ready;

  logic             fifo_full;
  logic             fifo_w_en;
  logic [WIDTH-1:0] fifo_data;

  logic [1:0]       grant;
  logic [LEN_W-1:0] frame_len;
  logic             frame_len_vld;
  logic [CNT_W-1:0] frame_cnt0;
  logic [CNT_W-1:0] frame_cnt1;

  modport slave (
    input  s0_data, s0_valid, s0_last,
    input  s1_data, s1_valid, s1_last,
    input  fifo_full,
    output s0_ready, s1_ready,
    output fifo_w_en, fifo_data,
    output grant, frame_len, frame_len_vld, frame_cnt0, frame_cnt1
  );

  modport master (
    output s0_data, s0_valid, s0_last,
    output s1_data, s1_valid, s1_last,
    output fifo_full,
    input  s0_ready, s1_ready,
    input  fifo_w_en, fifo_data,
    input  grant, frame_len, frame_len_vld, frame_cnt0, frame_cnt1
  );

endinterface

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Frame-level round-robin arbiter sharing one FIFO write port between two
// byte-stream requesters. A grant is held from the first beat of a frame until
// its last beat is accepted, so frames never interleave in the FIFO. FIFO full
// stalls the owner without losing or duplicating beats. Completed frames update
// a length report and per-requester counters.
//
// Ports
//   clk   write-side clock (FIFO wclk domain)
//   srst  synchronous reset, active high
//   bus   fifo_wr_arb_if.slave: requester handshakes, FIFO write port, status
//
// The requester -> FIFO path is purely combinational from the registered grant,
// giving zero-cycle latency and one beat per cycle inside a frame.
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 11,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          srst,
  fifo_wr_arb_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered state
  state_t           state_q;
  logic [1:0]       grant_q;
  logic             prio_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [LEN_W-1:0] frame_len_q;
  logic             frame_len_vld_q;
  logic [CNT_W-1:0] frame_cnt0_q;
  logic [CNT_W-1:0] frame_cnt1_q;

  // Combinational helpers
  logic             own_valid_s;
  logic             own_last_s;
  logic [WIDTH-1:0] own_data_s;
  logic             accept_s;
  logic             s0_ready_s;
  logic             s1_ready_s;
  logic [LEN_W-1:0] beats_d;

  // Select the current owner's beat; everything reads zero while idle.
  always_comb begin
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_data_s  = {WIDTH{1'b0}};
    case (grant_q)
      2'b01: begin
        own_valid_s = bus.s0_valid;
        own_last_s  = bus.s0_last;
        own_data_s  = bus.s0_data;
      end
      2'b10: begin
        own_valid_s = bus.s1_valid;
        own_last_s  = bus.s1_last;
        own_data_s  = bus.s1_data;
      end
      default: begin
        own_valid_s = 1'b0;
        own_last_s  = 1'b0;
        own_data_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // Handshake qualification: only the owner sees ready, and only while the
  // FIFO has room. Ready does not depend on valid.
  always_comb begin
    s0_ready_s = 1'b0;
    s1_ready_s = 1'b0;
    accept_s   = 1'b0;
    if (state_q == BUSY) begin
      s0_ready_s = grant_q[0] & ~bus.fifo_full;
      s1_ready_s = grant_q[1] & ~bus.fifo_full;
      accept_s   = own_valid_s & ~bus.fifo_full;
    end else begin
      s0_ready_s = 1'b0;
      s1_ready_s = 1'b0;
      accept_s   = 1'b0;
    end
  end

  // Beat count including the beat accepted this cycle, saturating at all-ones
  // so oversize frames report the maximum instead of wrapping to a small value.
  always_comb begin
    beats_d = beat_cnt_q;
    if (beat_cnt_q == LEN_MAX) begin
      beats_d = LEN_MAX;
    end else begin
      beats_d = beat_cnt_q + LEN_ONE;
    end
  end

  // Arbitration FSM, beat counter and status registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q         <= IDLE;
      grant_q         <= 2'b00;
      prio_q          <= 1'b0;
      beat_cnt_q      <= {LEN_W{1'b0}};
      frame_len_q     <= {LEN_W{1'b0}};
      frame_len_vld_q <= 1'b0;
      frame_cnt0_q    <= {CNT_W{1'b0}};
      frame_cnt1_q    <= {CNT_W{1'b0}};
    end else begin
      frame_len_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Arbitration is on valid only; a full FIFO does not stop granting.
          if (bus.s0_valid && (!bus.s1_valid || !prio_q)) begin
            state_q    <= BUSY;
            grant_q    <= 2'b01;
            beat_cnt_q <= {LEN_W{1'b0}};
          end else if (bus.s1_valid) begin
            state_q    <= BUSY;
            grant_q    <= 2'b10;
            beat_cnt_q <= {LEN_W{1'b0}};
          end else begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        BUSY: begin
          if (accept_s && own_last_s) begin
            state_q         <= IDLE;
            grant_q         <= 2'b00;
            // The finishing source loses priority to the other one.
            prio_q          <= grant_q[0];
            frame_len_q     <= beats_d;
            frame_len_vld_q <= 1'b1;
            beat_cnt_q      <= {LEN_W{1'b0}};
            if (grant_q[0]) begin
              frame_cnt0_q <= frame_cnt0_q + CNT_ONE;
            end else begin
              frame_cnt1_q <= frame_cnt1_q + CNT_ONE;
            end
          end else if (accept_s) begin
            beat_cnt_q <= beats_d;
          end else begin
            // Owner idle or FIFO full: hold the grant, no timeout.
            beat_cnt_q <= beat_cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  // Combinational datapath to the FIFO and requesters.
  assign bus.s0_ready      = s0_ready_s;
  assign bus.s1_ready      = s1_ready_s;
  assign bus.fifo_w_en     = accept_s;
  assign bus.fifo_data     = own_data_s;

  // Registered status outputs.
  assign bus.grant         = grant_q;
  assign bus.frame_len     = frame_len_q;
  assign bus.frame_len_vld = frame_len_vld_q;
  assign bus.frame_cnt0    = frame_cnt0_q;
  assign bus.frame_cnt1    = frame_cnt1_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb: a cycle table for single-owner frames,
// backpressure and single-beat frames, plus hand-written sequences for
// round-robin ordering, owner stall, length saturation and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

  logic clk;
  logic srst;

  fifo_wr_arb_if #(.WIDTH(8), .LEN_W(11), .CNT_W(16)) bus ();

  fifo_wr_arb #(.WIDTH(8), .LEN_W(11), .CNT_W(16)) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s0v;
    logic        s0l;
    logic [7:0]  s0d;
    logic        s1v;
    logic        s1l;
    logic [7:0]  s1d;
    logic        full;
    logic [1:0]  grant;
    logic        s0r;
    logic        s1r;
    logic        wen;
    logic [7:0]  fdata;
    logic        vld;
    logic [10:0] flen;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
  } vec_t;

  vec_t tbl [21];

  int total;
  int bad;

  function automatic vec_t mk(
    input logic s0v, input logic s0l, input logic [7:0] s0d,
    input logic s1v, input logic s1l, input logic [7:0] s1d,
    input logic full,
    input logic [1:0] grant, input logic s0r, input logic s1r,
    input logic wen, input logic [7:0] fdata, input logic vld,
    input logic [10:0] flen, input logic [15:0] cnt0, input logic [15:0] cnt1);
    vec_t v;
    v.s0v = s0v; v.s0l = s0l; v.s0d = s0d;
    v.s1v = s1v; v.s1l = s1l; v.s1d = s1d;
    v.full = full;
    v.grant = grant; v.s0r = s0r; v.s1r = s1r; v.wen = wen;
    v.fdata = fdata; v.vld = vld; v.flen = flen; v.cnt0 = cnt0; v.cnt1 = cnt1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.s0_valid = 1'b0; bus.s0_last = 1'b0; bus.s0_data = 8'h00;
    bus.s1_valid = 1'b0; bus.s1_last = 1'b0; bus.s1_data = 8'h00;
    bus.fifo_full = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    idle_inputs();
    srst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
  endtask

  // Sequence variables
  int f0, b0, f1, b1, np, p, w, src, bt, ec;
  logic [7:0] ed;
  logic [7:0] wd [$];
  int wc [$];
  int i_beat, nwr;
  logic got;
  logic [10:0] len_cap;

  initial begin
    total = 0;
    bad   = 0;
    srst  = 1'b1;

    // Table rows: inputs for the cycle, then outputs expected in that cycle.
    //            s0v  s0l  s0d    s1v  s1l  s1d    full  grant  s0r  s1r  wen  fdata  vld  flen cnt0 cnt1
    tbl[0]  = mk(1'b1,1'b0,8'hA0, 1'b0,1'b0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b0,11'd0,16'd0,16'd0);
    tbl[1]  = mk(1'b1,1'b0,8'hA0, 1'b0,1'b0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1,8'hA0,1'b0,11'd0,16'd0,16'd0);
    tbl[2]  = mk(1'b1,1'b0,8'hA1, 1'b0,1'b0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1,8'hA1,1'b0,11'd0,16'd0,16'd0);
    tbl[3]  = mk(1'b1,1'b0,8'hA2, 1'b0,1'b0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1,8'hA2,1'b0,11'd0,16'd0,16'd0);
    tbl[4]  = mk(1'b1,1'b1,8'hA3, 1'b0,1'b0,8'h00, 1'b0, 2'b01,1'b1,1'b0,1'b1,8'hA3,1'b0,11'd0,16'd0,16'd0);
    tbl[5]  = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b1,11'd4,16'd1,16'd0);
    tbl[6]  = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b0,11'd4,16'd1,16'd0);
    tbl[7]  = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB0, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b0,11'd4,16'd1,16'd0);
    tbl[8]  = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB0, 1'b0, 2'b10,1'b0,1'b1,1'b1,8'hB0,1'b0,11'd4,16'd1,16'd0);
    tbl[9]  = mk(1'b0,1'b1,8'h77, 1'b1,1'b0,8'hB1, 1'b0, 2'b10,1'b0,1'b1,1'b1,8'hB1,1'b0,11'd4,16'd1,16'd0);
    tbl[10] = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB2, 1'b1, 2'b10,1'b0,1'b0,1'b0,8'hB2,1'b0,11'd4,16'd1,16'd0);
    tbl[11] = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB2, 1'b1, 2'b10,1'b0,1'b0,1'b0,8'hB2,1'b0,11'd4,16'd1,16'd0);
    tbl[12] = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB2, 1'b1, 2'b10,1'b0,1'b0,1'b0,8'hB2,1'b0,11'd4,16'd1,16'd0);
    tbl[13] = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB2, 1'b0, 2'b10,1'b0,1'b1,1'b1,8'hB2,1'b0,11'd4,16'd1,16'd0);
    tbl[14] = mk(1'b0,1'b0,8'h00, 1'b1,1'b0,8'hB3, 1'b0, 2'b10,1'b0,1'b1,1'b1,8'hB3,1'b0,11'd4,16'd1,16'd0);
    tbl[15] = mk(1'b0,1'b0,8'h00, 1'b1,1'b1,8'hB4, 1'b1, 2'b10,1'b0,1'b0,1'b0,8'hB4,1'b0,11'd4,16'd1,16'd0);
    tbl[16] = mk(1'b0,1'b0,8'h00, 1'b1,1'b1,8'hB4, 1'b0, 2'b10,1'b0,1'b1,1'b1,8'hB4,1'b0,11'd4,16'd1,16'd0);
    tbl[17] = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b1,11'd5,16'd1,16'd1);
    tbl[18] = mk(1'b0,1'b0,8'h00, 1'b1,1'b1,8'hC5, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b0,11'd5,16'd1,16'd1);
    tbl[19] = mk(1'b0,1'b0,8'h00, 1'b1,1'b1,8'hC5, 1'b0, 2'b10,1'b0,1'b1,1'b1,8'hC5,1'b0,11'd5,16'd1,16'd1);
    tbl[20] = mk(1'b0,1'b0,8'h00, 1'b0,1'b0,8'h00, 1'b0, 2'b00,1'b0,1'b0,1'b0,8'h00,1'b1,11'd1,16'd1,16'd2);

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_s0_ready", 32'(bus.s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(bus.s1_ready), 32'd0);
    chk("rst_w_en", 32'(bus.fifo_w_en), 32'd0);
    chk("rst_fdata", 32'(bus.fifo_data), 32'd0);
    chk("rst_vld", 32'(bus.frame_len_vld), 32'd0);
    chk("rst_len", 32'(bus.frame_len), 32'd0);
    chk("rst_cnt0", 32'(bus.frame_cnt0), 32'd0);
    chk("rst_cnt1", 32'(bus.frame_cnt1), 32'd0);
    @(negedge clk);

    // ---------------- table ----------------
    for (int r = 0; r < 21; r++) begin
      bus.s0_valid = tbl[r].s0v; bus.s0_last = tbl[r].s0l; bus.s0_data = tbl[r].s0d;
      bus.s1_valid = tbl[r].s1v; bus.s1_last = tbl[r].s1l; bus.s1_data = tbl[r].s1d;
      bus.fifo_full = tbl[r].full;
      #1;
      chk($sformatf("row%0d_grant", r), 32'(bus.grant), 32'(tbl[r].grant));
      chk($sformatf("row%0d_s0_ready", r), 32'(bus.s0_ready), 32'(tbl[r].s0r));
      chk($sformatf("row%0d_s1_ready", r), 32'(bus.s1_ready), 32'(tbl[r].s1r));
      chk($sformatf("row%0d_w_en", r), 32'(bus.fifo_w_en), 32'(tbl[r].wen));
      chk($sformatf("row%0d_fdata", r), 32'(bus.fifo_data), 32'(tbl[r].fdata));
      chk($sformatf("row%0d_vld", r), 32'(bus.frame_len_vld), 32'(tbl[r].vld));
      chk($sformatf("row%0d_len", r), 32'(bus.frame_len), 32'(tbl[r].flen));
      chk($sformatf("row%0d_cnt0", r), 32'(bus.frame_cnt0), 32'(tbl[r].cnt0));
      chk($sformatf("row%0d_cnt1", r), 32'(bus.frame_cnt1), 32'(tbl[r].cnt1));
      @(negedge clk);
    end

    // ---------------- round robin, both valid from reset ----------------
    do_reset();
    f0 = 0; b0 = 0; f1 = 0; b1 = 0; np = 0;
    for (int c = 0; c < 18; c++) begin
      bus.s0_valid = (f0 < 2);
      bus.s0_data  = 8'h10 + 8'(f0 * 4 + b0);
      bus.s0_last  = (b0 == 2);
      bus.s1_valid = (f1 < 2);
      bus.s1_data  = 8'h20 + 8'(f1 * 4 + b1);
      bus.s1_last  = (b1 == 2);
      #1;
      if (bus.fifo_w_en) begin
        wd.push_back(bus.fifo_data);
        wc.push_back(c);
      end
      if (bus.frame_len_vld) begin
        np++;
        chk("rr_len", 32'(bus.frame_len), 32'd3);
        chk("rr_cnt0", 32'(bus.frame_cnt0), 32'((np + 1) / 2));
        chk("rr_cnt1", 32'(bus.frame_cnt1), 32'(np / 2));
      end
      if (bus.s0_valid && bus.s0_ready) begin
        if (b0 == 2) begin b0 = 0; f0++; end else b0++;
      end
      if (bus.s1_valid && bus.s1_ready) begin
        if (b1 == 2) begin b1 = 0; f1++; end else b1++;
      end
      @(negedge clk);
    end
    chk("rr_frames", 32'(np), 32'd4);
    chk("rr_writes", 32'(wd.size()), 32'd12);
    for (int k = 0; k < 12 && k < wd.size(); k++) begin
      p   = k / 6;
      w   = k % 6;
      src = w / 3;
      bt  = w % 3;
      ed  = ((src == 1) ? 8'h20 : 8'h10) + 8'(p * 4 + bt);
      ec  = (k / 3) * 4 + (k % 3) + 1;
      chk($sformatf("rr_data%0d", k), 32'(wd[k]), 32'(ed));
      chk($sformatf("rr_cyc%0d", k), 32'(wc[k]), 32'(ec));
    end

    // ---------------- owner drops valid, other waits ----------------
    do_reset();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h30; bus.s1_valid = 1'b1; bus.s1_data = 8'h40;
    #1; chk("hold_c0_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    #1; chk("hold_b0_w_en", 32'(bus.fifo_w_en), 32'd1);
    chk("hold_b0_grant", 32'(bus.grant), 32'd1);
    @(negedge clk);
    bus.s0_data = 8'h31;
    #1; chk("hold_b1_data", 32'(bus.fifo_data), 32'h31);
    @(negedge clk);
    bus.s0_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("hold_gap%0d_s1_ready", c), 32'(bus.s1_ready), 32'd0);
      chk($sformatf("hold_gap%0d_grant", c), 32'(bus.grant), 32'd1);
      chk($sformatf("hold_gap%0d_w_en", c), 32'(bus.fifo_w_en), 32'd0);
      @(negedge clk);
    end
    bus.s0_valid = 1'b1; bus.s0_last = 1'b1; bus.s0_data = 8'h32;
    #1; chk("hold_last_w_en", 32'(bus.fifo_w_en), 32'd1);
    chk("hold_last_data", 32'(bus.fifo_data), 32'h32);
    @(negedge clk);
    bus.s0_valid = 1'b0; bus.s0_last = 1'b0;
    #1; chk("hold_end_grant", 32'(bus.grant), 32'd0);
    chk("hold_end_vld", 32'(bus.frame_len_vld), 32'd1);
    chk("hold_end_len", 32'(bus.frame_len), 32'd3);
    @(negedge clk);
    #1; chk("hold_s1_grant", 32'(bus.grant), 32'd2);
    chk("hold_s1_ready", 32'(bus.s1_ready), 32'd1);
    chk("hold_s1_data", 32'(bus.fifo_data), 32'h40);
    @(negedge clk);

    // ---------------- length saturation ----------------
    do_reset();
    i_beat = 0; nwr = 0; got = 1'b0; len_cap = 11'd0;
    for (int c = 0; c < 2300 && !got; c++) begin
      bus.s0_valid = (i_beat < 2100);
      bus.s0_data  = 8'(i_beat);
      bus.s0_last  = (i_beat == 2099);
      #1;
      if (bus.fifo_w_en) nwr++;
      if (bus.s0_valid && bus.s0_ready) i_beat++;
      if (bus.frame_len_vld) begin
        got = 1'b1;
        len_cap = bus.frame_len;
      end
      @(negedge clk);
    end
    chk("sat_pulse_seen", 32'(got), 32'd1);
    chk("sat_len", 32'(len_cap), 32'd2047);
    chk("sat_writes", 32'(nwr), 32'd2100);

    // ---------------- reset mid-frame ----------------
    idle_inputs();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h50;
    #1; chk("srst_pre_cnt0", 32'(bus.frame_cnt0), 32'd1);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      bus.s0_data = 8'h50 + 8'(j);
      if (j == 3) srst = 1'b1;
      #1;
      chk($sformatf("srst_beat%0d_w_en", j), 32'(bus.fifo_w_en), 32'd1);
      @(negedge clk);
    end
    srst = 1'b0;
    bus.s1_valid = 1'b1; bus.s1_data = 8'h60;
    #1;
    chk("srst_grant", 32'(bus.grant), 32'd0);
    chk("srst_vld", 32'(bus.frame_len_vld), 32'd0);
    chk("srst_len", 32'(bus.frame_len), 32'd0);
    chk("srst_cnt0", 32'(bus.frame_cnt0), 32'd0);
    chk("srst_cnt1", 32'(bus.frame_cnt1), 32'd0);
    @(negedge clk);
    #1;
    chk("srst_prio_grant", 32'(bus.grant), 32'd1);
    @(negedge clk);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
